// File: rtl/loop_sample_buffer.sv
// loop_sample_buffer: loop audio store driven by the looper control FSM.
//   Records sample_in into internal RAM while rec_en is high. Replays the captured
//   loop, wrapping, while play_en is high. Pulses rec_done when the buffer fills.
//
// Ports
//   clk              system clock
//   rst_n            synchronous reset, active low (loop discarded, RAM kept)
//   rec_en           record enable (level), wins over play_en
//   play_en          play enable (level)
//   sample_valid     one-cycle audio-rate strobe
//   sample_in        input sample, qualified by sample_valid
//   sample_out       playback sample, registered, zero outside PLAY
//   sample_out_valid one-cycle pulse, sample_out updated
//   rec_done         one-cycle pulse, buffer filled during record
//   loop_len         number of samples in the current loop
//   loop_valid       committed loop present
//   play_wrap        pulses with the output of loop sample 0
module loop_sample_buffer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MAX_SAMPLES = 64000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic              rec_done,
  output logic [ADDR_W-1:0] loop_len,
  output logic              loop_valid,
  output logic              play_wrap
);

  localparam int unsigned IdxW = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StRec, StPlay} mode_e;

  mode_e mode_q, mode_d;

  logic [DATA_W-1:0] mem [MAX_SAMPLES];

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] loop_len_q, loop_len_d;
  logic              loop_valid_q, loop_valid_d;
  logic              full_q, full_d;
  logic              rec_done_q, rec_done_d;
  logic [DATA_W-1:0] sample_out_q, sample_out_d;
  logic              sample_out_valid_q, sample_out_valid_d;
  logic              play_wrap_q, play_wrap_d;

  logic              rec_entry, rec_exit, play_entry;
  logic              full_eff, loop_valid_eff;
  logic              wr_en, rd_en, wr_last, rd_last;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_next;

  // Effective mode is this cycle's request, so the entry cycle already writes or reads
  // address 0 and a strobe on the PLAY exit cycle is dropped.
  always_comb begin
    mode_d = StIdle;
    if (rec_en) begin
      mode_d = StRec;
    end else if (play_en) begin
      mode_d = StPlay;
    end
  end

  always_comb begin
    rec_entry  = (mode_d == StRec) && (mode_q != StRec);
    rec_exit   = (mode_q == StRec) && (mode_d != StRec);
    play_entry = (mode_d == StPlay) && (mode_q != StPlay);

    wr_ptr   = rec_entry ? '0 : wr_addr_q;
    full_eff = rec_entry ? 1'b0 : full_q;
    wr_en    = (mode_d == StRec) && sample_valid && !full_eff;
    wr_last  = (wr_ptr == LastAddr);

    // A REC->PLAY switch commits the loop on the same edge playback starts.
    loop_valid_eff = rec_exit ? (loop_len_q != '0) : loop_valid_q;
    rd_ptr         = play_entry ? '0 : rd_addr_q;
    rd_next        = rd_ptr + ADDR_W'(1);
    rd_last        = (rd_next == loop_len_q);
    rd_en          = (mode_d == StPlay) && sample_valid;
  end

  always_comb begin
    wr_addr_d          = wr_ptr;
    loop_len_d         = rec_entry ? '0 : loop_len_q;
    full_d             = full_eff;
    rec_done_d         = 1'b0;
    loop_valid_d       = loop_valid_q;
    rd_addr_d          = rd_ptr;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    play_wrap_d        = 1'b0;

    if (wr_en) begin
      wr_addr_d  = wr_ptr + ADDR_W'(1);
      loop_len_d = wr_ptr + ADDR_W'(1);
      if (wr_last) begin
        full_d     = 1'b1;
        rec_done_d = 1'b1;
      end
    end

    if (rec_entry) begin
      loop_valid_d = 1'b0;
    end else if (rec_exit) begin
      loop_valid_d = (loop_len_q != '0);
    end

    if (mode_d != StPlay) begin
      sample_out_d = '0;
    end else if (rd_en) begin
      sample_out_valid_d = 1'b1;
      if (loop_valid_eff) begin
        sample_out_d = mem[rd_ptr[IdxW-1:0]];
        play_wrap_d  = (rd_ptr == '0);
        rd_addr_d    = rd_last ? '0 : rd_next;
      end else begin
        // No loop: emit silence at audio rate, pointer frozen.
        sample_out_d = '0;
      end
    end
  end

  // RAM is not reset; REC and PLAY are exclusive so a single port suffices.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[IdxW-1:0]] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q             <= StIdle;
      wr_addr_q          <= '0;
      rd_addr_q          <= '0;
      loop_len_q         <= '0;
      loop_valid_q       <= 1'b0;
      full_q             <= 1'b0;
      rec_done_q         <= 1'b0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      play_wrap_q        <= 1'b0;
    end else begin
      mode_q             <= mode_d;
      wr_addr_q          <= wr_addr_d;
      rd_addr_q          <= rd_addr_d;
      loop_len_q         <= loop_len_d;
      loop_valid_q       <= loop_valid_d;
      full_q             <= full_d;
      rec_done_q         <= rec_done_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      play_wrap_q        <= play_wrap_d;
    end
  end

  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign rec_done         = rec_done_q;
  assign loop_len         = loop_len_q;
  assign loop_valid       = loop_valid_q;
  assign play_wrap        = play_wrap_q;

endmodule

// File: tb/tb_loop_sample_buffer.sv
module tb_loop_sample_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned MAX_S  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rec_en = 1'b0;
  logic              play_en = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_out_valid;
  logic              rec_done;
  logic [ADDR_W-1:0] loop_len;
  logic              loop_valid;
  logic              play_wrap;

  loop_sample_buffer #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MAX_SAMPLES (MAX_S)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rec_en           (rec_en),
    .play_en          (play_en),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .rec_done         (rec_done),
    .loop_len         (loop_len),
    .loop_valid       (loop_valid),
    .play_wrap        (play_wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              wrap;
    int                at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_pulses = 0;
  int   done_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    forever begin
      @(negedge clk);
      if (rec_done === 1'b1) begin
        done_pulses++;
        done_cyc = cyc;
      end
      if (play_wrap === 1'b1 && sample_out_valid !== 1'b1) begin
        n_cmp++;
        n_err++;
        $display("FAIL wrap_without_valid: got play_wrap=1, expected 0 (cycle %0d)", cyc);
      end
      if (sample_out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got sample_out=%0d, expected no output (cycle %0d)",
                   sample_out, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sample_out", 32'(sample_out), 32'(e.data));
          check("play_wrap", 32'(play_wrap), 32'(e.wrap));
          check("out_latency", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_strobe(input logic [DATA_W-1:0] d);
    sample_valid = 1'b1;
    sample_in    = d;
    tick();
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic play_strobe(input logic [DATA_W-1:0] d, input logic w);
    exp_q.push_back('{data: d, wrap: w, at: cyc + 1});
    sample_valid = 1'b1;
    sample_in    = 16'hbeef;
    tick();
    sample_valid = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    int c8;
    logic [DATA_W-1:0] seq2 [12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};

    // Reset state
    tick();
    tick();
    check("rst_sample_out", 32'(sample_out), 0);
    check("rst_out_valid", 32'(sample_out_valid), 0);
    check("rst_rec_done", 32'(rec_done), 0);
    check("rst_loop_len", 32'(loop_len), 0);
    check("rst_loop_valid", 32'(loop_valid), 0);
    check("rst_play_wrap", 32'(play_wrap), 0);
    rst_n = 1'b1;
    tick();

    // 1: record 1..5
    rec_en = 1'b1;
    for (int i = 1; i <= 5; i++) rec_strobe(DATA_W'(i));
    check("t1_loop_valid_during_rec", 32'(loop_valid), 0);
    rec_en = 1'b0;
    tick();
    check("t1_loop_len", 32'(loop_len), 5);
    check("t1_loop_valid", 32'(loop_valid), 1);
    check("t1_rec_done_count", 32'(done_pulses), 0);

    // 2: play 12 strobes, wraps at outputs 1, 6, 11
    play_en = 1'b1;
    for (int i = 0; i < 12; i++) play_strobe(seq2[i], (i % 5) == 0);
    // Strobe on the PLAY exit cycle is dropped
    play_en      = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    check("t2_out_zero_after_exit", 32'(sample_out), 0);
    check("t2_rec_done_count", 32'(done_pulses), 0);

    // 3: overfill with rec_en held
    base   = done_pulses;
    c8     = -1;
    rec_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) c8 = cyc;
      rec_strobe(DATA_W'(10 + i));
    end
    check("t3_rec_done_count", 32'(done_pulses - base), 1);
    check("t3_rec_done_cycle", 32'(done_cyc), 32'(c8 + 1));
    check("t3_loop_len", 32'(loop_len), 8);
    rec_en = 1'b0;
    tick();
    check("t3_loop_valid", 32'(loop_valid), 1);
    play_en = 1'b1;
    for (int i = 0; i < 10; i++) play_strobe(DATA_W'(11 + (i % 8)), (i % 8) == 0);
    play_en = 1'b0;
    tick();

    // 4: rec_en and play_en together on an empty buffer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rec_en  = 1'b1;
    play_en = 1'b1;
    rec_strobe(21);
    rec_strobe(22);
    rec_strobe(23);
    check("t4_loop_valid_in_rec", 32'(loop_valid), 0);
    check("t4_loop_len", 32'(loop_len), 3);
    // Drop rec_en with a strobe on the same cycle: sample 0 plays at once
    exp_q.push_back('{data: 21, wrap: 1'b1, at: cyc + 1});
    rec_en       = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    check("t4_loop_valid_commit", 32'(loop_valid), 1);
    play_strobe(22, 1'b0);
    play_strobe(23, 1'b0);
    play_strobe(21, 1'b1);

    // 5: reset mid-play
    check("t5_pre_out_nonzero", 32'(sample_out), 21);
    rst_n = 1'b0;
    tick();
    check("t5_sample_out", 32'(sample_out), 0);
    check("t5_loop_valid", 32'(loop_valid), 0);
    check("t5_loop_len", 32'(loop_len), 0);
    check("t5_out_valid", 32'(sample_out_valid), 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) play_strobe(0, 1'b0);
    play_en = 1'b0;
    tick();

    // 6: re-record 7,8,9 over a 5-sample loop
    rec_en = 1'b1;
    for (int i = 1; i <= 5; i++) rec_strobe(DATA_W'(i));
    rec_en = 1'b0;
    tick();
    check("t6_first_len", 32'(loop_len), 5);
    rec_en = 1'b1;
    rec_strobe(7);
    rec_strobe(8);
    rec_strobe(9);
    rec_en = 1'b0;
    tick();
    check("t6_loop_len", 32'(loop_len), 3);
    check("t6_loop_valid", 32'(loop_valid), 1);
    play_en = 1'b1;
    play_strobe(7, 1'b1);
    play_strobe(8, 1'b0);
    play_strobe(9, 1'b0);
    play_strobe(7, 1'b1);
    play_strobe(8, 1'b0);
    play_en = 1'b0;
    tick();
    check("t6_out_zero_after_exit", 32'(sample_out), 0);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
